dsp_preadd_mult_stage: RTL and testbench

- Stage directly downstream of the DSP slice input registers (D, B, A0/A1 register-or-bypass muxes).
- Forms the pre-adder result D±B and selects between it and B to give B1, optionally registered.
- Multiplies A1 by B1 into a 36-bit M, optionally registered; M feeds the post-adder/accumulator stage.
- Carries a valid bit alongside the data so downstream logic can track pipeline fill.

---
 rtl/dsp_preadd_mult_stage_if.sv | 30 +++
 rtl/dsp_preadd_mult_stage.sv | 114 +++++++++++
 tb/tb_dsp_preadd_mult_stage.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_preadd_mult_stage_if.sv
// Operand, control and result bundle for the pre-adder/multiplier stage.
// Controls are sampled on the rising clock edge.
interface dsp_preadd_mult_stage_if #(
   parameter int WIDTH = 18
);
   localparam int PWIDTH = 2 * WIDTH;

   logic              rstb;
   logic              rstm;
   logic              ceb;
   logic              cem;
   logic [1:0]        opmode;
   logic [WIDTH-1:0]  d_in;
   logic [WIDTH-1:0]  b_in;
   logic [WIDTH-1:0]  a1_in;
   logic              valid_in;
   logic [WIDTH-1:0]  bcout;
   logic [PWIDTH-1:0] m_out;
   logic              valid_out;

   modport master (
      output rstb, rstm, ceb, cem, opmode, d_in, b_in, a1_in, valid_in,
      input  bcout, m_out, valid_out
   );

   modport slave (
      input  rstb, rstm, ceb, cem, opmode, d_in, b_in, a1_in, valid_in,
      output bcout, m_out, valid_out
   );
endinterface

// File: rtl/dsp_preadd_mult_stage.sv
// DSP slice pre-adder, B1 select/register and A1*B1 multiplier with optional M register.
// A valid bit travels with the data; it is not a backpressure handshake.
module dsp_preadd_mult_stage #(
   parameter int B1REG  = 1,
   parameter int MREG   = 1,
   parameter int WIDTH  = 18,
   parameter int PWIDTH = 2 * WIDTH
) (
   input logic                    clk,
   input logic                    rst,
   dsp_preadd_mult_stage_if.slave bus
);

   logic [WIDTH-1:0]  pre;
   logic [WIDTH-1:0]  b1_next;
   logic [WIDTH-1:0]  b1;
   logic              v1;
   logic [PWIDTH-1:0] prod;
   logic [PWIDTH-1:0] m;
   logic              vm;

   // Pre-adder wraps modulo 2^WIDTH; no carry or borrow leaves the stage.
   always_comb begin
      pre     = '0;
      b1_next = '0;
      if (bus.opmode[1]) begin
         pre = bus.d_in - bus.b_in;
      end else begin
         pre = bus.d_in + bus.b_in;
      end
      b1_next = bus.opmode[0] ? pre : bus.b_in;
   end

   generate
      if (B1REG != 0) begin : g_b1_reg
         logic [WIDTH-1:0] b1_q, b1_d;
         logic             v1_q, v1_d;

         // rstb outranks ceb.
         always_comb begin
            b1_d = b1_q;
            v1_d = v1_q;
            if (bus.rstb) begin
               b1_d = '0;
               v1_d = 1'b0;
            end else if (bus.ceb) begin
               b1_d = b1_next;
               v1_d = bus.valid_in;
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               b1_q <= '0;
               v1_q <= 1'b0;
            end else begin
               b1_q <= b1_d;
               v1_q <= v1_d;
            end
         end

         assign b1 = b1_q;
         assign v1 = v1_q;
      end else begin : g_b1_bypass
         assign b1 = b1_next;
         assign v1 = bus.valid_in;
      end
   endgenerate

   // a1_in is taken as presented; upstream A-path depth must line up with B1.
   always_comb begin
      prod = PWIDTH'(bus.a1_in) * PWIDTH'(b1);
   end

   generate
      if (MREG != 0) begin : g_m_reg
         logic [PWIDTH-1:0] m_q, m_d;
         logic              vm_q, vm_d;

         always_comb begin
            m_d  = m_q;
            vm_d = vm_q;
            if (bus.rstm) begin
               m_d  = '0;
               vm_d = 1'b0;
            end else if (bus.cem) begin
               m_d  = prod;
               vm_d = v1;
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               m_q  <= '0;
               vm_q <= 1'b0;
            end else begin
               m_q  <= m_d;
               vm_q <= vm_d;
            end
         end

         assign m  = m_q;
         assign vm = vm_q;
      end else begin : g_m_bypass
         assign m  = prod;
         assign vm = v1;
      end
   endgenerate

   assign bus.bcout     = b1;
   assign bus.m_out     = m;
   assign bus.valid_out = vm;

endmodule

// File: tb/tb_dsp_preadd_mult_stage.sv
// Directed bench for dsp_preadd_mult_stage: registered, fully bypassed and M-only builds
// share one stimulus stream; expected values come from a queue filled at drive time.
module tb_dsp_preadd_mult_stage;

   localparam int W  = 18;
   localparam int PW = 36;

   logic clk;
   logic rst;

   dsp_preadd_mult_stage_if #(.WIDTH(W)) bus   ();
   dsp_preadd_mult_stage_if #(.WIDTH(W)) bus00 ();
   dsp_preadd_mult_stage_if #(.WIDTH(W)) bus01 ();

   dsp_preadd_mult_stage #(.B1REG(1), .MREG(1), .WIDTH(W)) dut (
      .clk (clk), .rst (rst), .bus (bus.slave)
   );
   dsp_preadd_mult_stage #(.B1REG(0), .MREG(0), .WIDTH(W)) dut00 (
      .clk (clk), .rst (rst), .bus (bus00.slave)
   );
   dsp_preadd_mult_stage #(.B1REG(0), .MREG(1), .WIDTH(W)) dut01 (
      .clk (clk), .rst (rst), .bus (bus01.slave)
   );

   assign bus00.rstb = bus.rstb;     assign bus01.rstb = bus.rstb;
   assign bus00.rstm = bus.rstm;     assign bus01.rstm = bus.rstm;
   assign bus00.ceb = bus.ceb;       assign bus01.ceb = bus.ceb;
   assign bus00.cem = bus.cem;       assign bus01.cem = bus.cem;
   assign bus00.opmode = bus.opmode; assign bus01.opmode = bus.opmode;
   assign bus00.d_in = bus.d_in;     assign bus01.d_in = bus.d_in;
   assign bus00.b_in = bus.b_in;     assign bus01.b_in = bus.b_in;
   assign bus00.a1_in = bus.a1_in;   assign bus01.a1_in = bus.a1_in;
   assign bus00.valid_in = bus.valid_in;
   assign bus01.valid_in = bus.valid_in;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard
   logic [PW-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_pop(input string tag, input logic [PW-1:0] obs);
      logic [PW-1:0] exp;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=0x%0h expected=<empty queue>", tag, obs);
      end else begin
         exp = exp_q.pop_front();
         check(tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_b1(input logic [1:0] op, input logic [W-1:0] d,
                                           input logic [W-1:0] b);
      logic [W-1:0] p;
      p = op[1] ? (d - b) : (d + b);
      return op[0] ? p : b;
   endfunction

   function automatic logic [PW-1:0] ref_m(input logic [W-1:0] a, input logic [W-1:0] b1v);
      logic [PW-1:0] aa, bb;
      aa = {{(PW-W){1'b0}}, a};
      bb = {{(PW-W){1'b0}}, b1v};
      return aa * bb;
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [W-1:0] d, input logic [W-1:0] b,
                        input logic [W-1:0] a, input logic v);
      bus.opmode   = op;
      bus.d_in     = d;
      bus.b_in     = b;
      bus.a1_in    = a;
      bus.valid_in = v;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      bus.rstb = 1'b0;
      bus.rstm = 1'b0;
      bus.ceb  = 1'b1;
      bus.cem  = 1'b1;
      drive(2'b00, '0, '0, '0, 1'b0);
      #3;
      check("rst_bcout", bus.bcout, '0);
      check("rst_m_out", bus.m_out, '0);
      check("rst_valid", {35'd0, bus.valid_out}, '0);
      tick();
      rst = 1'b1;

      // add through the pre-adder
      drive(2'b01, 18'd100, 18'd23, 18'd2, 1'b1);
      exp_q.push_back(36'd123);
      exp_q.push_back(36'd246);
      #1;
      check("byp_add_m", bus00.m_out, ref_m(18'd2, ref_b1(2'b01, 18'd100, 18'd23)));
      check("byp_add_v", {35'd0, bus00.valid_out}, 36'd1);
      check("byp_add_bc", bus00.bcout, 36'd123);
      check("mreg_pre_edge", bus01.m_out, '0);
      tick();
      check_pop("add_bcout", bus.bcout);
      check("mreg_one_cycle", bus01.m_out, 36'd246);
      check("mreg_valid", {35'd0, bus01.valid_out}, 36'd1);
      check("add_valid_early", {35'd0, bus.valid_out}, '0);
      tick();
      check_pop("add_m_out", bus.m_out);
      check("add_valid", {35'd0, bus.valid_out}, 36'd1);

      // subtract wraps modulo 2^18
      drive(2'b11, 18'd5, 18'd10, 18'd1, 1'b1);
      exp_q.push_back(36'h3FFFB);
      exp_q.push_back(36'h3FFFB);
      #1;
      check("byp_sub_m", bus00.m_out, 36'h3FFFB);
      tick();
      check_pop("sub_bcout", bus.bcout);
      tick();
      check_pop("sub_m_out", bus.m_out);

      // pass B, full-width product
      drive(2'b00, 18'd7, 18'h3FFFF, 18'h3FFFF, 1'b1);
      exp_q.push_back(36'h3FFFF);
      exp_q.push_back(36'hFFFF80001);
      #1;
      check("byp_pass_m", bus00.m_out, ref_m(18'h3FFFF, ref_b1(2'b00, 18'd7, 18'h3FFFF)));
      tick();
      check_pop("pass_bcout", bus.bcout);
      tick();
      check_pop("pass_m_out", bus.m_out);

      // async reset between edges
      #2;
      rst = 1'b0;
      #1;
      check("async_bcout", bus.bcout, '0);
      check("async_m_out", bus.m_out, '0);
      check("async_valid", {35'd0, bus.valid_out}, '0);
      bus.ceb = 1'b0;
      bus.cem = 1'b0;
      drive(2'b01, 18'd9, 18'd9, 18'd9, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      check("idle_bcout", bus.bcout, '0);
      check("idle_m_out", bus.m_out, '0);
      check("idle_valid", {35'd0, bus.valid_out}, '0);

      // first valid after reset appears two cycles later
      bus.ceb = 1'b1;
      bus.cem = 1'b1;
      drive(2'b01, 18'd1, 18'd2, 18'd5, 1'b1);
      exp_q.push_back(36'd3);
      exp_q.push_back(36'd15);
      tick();
      check_pop("restart_bcout", bus.bcout);
      check("restart_valid_early", {35'd0, bus.valid_out}, '0);
      tick();
      check_pop("restart_m_out", bus.m_out);
      check("restart_valid", {35'd0, bus.valid_out}, 36'd1);

      // stall: B1 held at 50 while a1 steps
      drive(2'b00, 18'd0, 18'd50, 18'd1, 1'b1);
      tick();
      bus.ceb = 1'b0;
      bus.b_in = 18'd999;
      for (int i = 1; i <= 3; i++) begin
         exp_q.push_back(ref_m(18'(i), 18'd50));
         tick();
         check_pop("stall_m_out", bus.m_out);
         check("stall_bcout", bus.bcout, 36'd50);
         bus.a1_in = 18'(i + 1);
      end
      bus.a1_in = 18'd3;
      bus.rstb = 1'b1;
      bus.ceb  = 1'b1;
      tick();
      check("rstb_bcout", bus.bcout, '0);

      // rstb and rstm together with cem high: no M load
      bus.rstb = 1'b0;
      drive(2'b00, 18'd0, 18'd7, 18'd3, 1'b1);
      tick();
      check("reload_bcout", bus.bcout, 36'd7);
      bus.rstb = 1'b1;
      bus.rstm = 1'b1;
      tick();
      check("dual_rst_bcout", bus.bcout, '0);
      check("dual_rst_m_out", bus.m_out, '0);
      check("dual_rst_valid", {35'd0, bus.valid_out}, '0);

      // cem low holds M
      bus.rstb = 1'b0;
      bus.rstm = 1'b0;
      drive(2'b00, 18'd0, 18'd4, 18'd6, 1'b1);
      exp_q.push_back(36'd24);
      exp_q.push_back(36'd24);
      tick();
      tick();
      check_pop("cem_load_m", bus.m_out);
      bus.cem = 1'b0;
      bus.a1_in = 18'd9;
      tick();
      check_pop("cem_hold_m", bus.m_out);

      // random pass-through on the fully bypassed build
      for (int i = 0; i < 8; i++) begin
         logic [1:0]   op;
         logic [W-1:0] d, b, a;
         op = 2'($urandom_range(0, 3));
         d  = 18'($urandom_range(0, 262143));
         b  = 18'($urandom_range(0, 262143));
         a  = 18'($urandom_range(0, 262143));
         drive(op, d, b, a, 1'($urandom_range(0, 1)));
         exp_q.push_back(ref_m(a, ref_b1(op, d, b)));
         #1;
         check_pop("rand_byp_m", bus00.m_out);
         check("rand_byp_v", {35'd0, bus00.valid_out}, {35'd0, bus.valid_in});
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
